// File: rtl/lfsr_prbs_checker_if.sv
// Stream and status bundle between a PRBS source and the lfsr_prbs_checker.
// The master drives the serial stream and counter clear; the slave (checker)
// returns lock status and error reporting.
interface lfsr_prbs_checker_if #(
   parameter int unsigned CNT_W = 16
) ();

   logic             in_valid;
   logic             in_bit;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output in_valid,
      output in_bit,
      output clr_cnt,
      input  locked,
      input  err_pulse,
      input  err_cnt
   );

   modport slave (
      input  in_valid,
      input  in_bit,
      input  clr_cnt,
      output locked,
      output err_pulse,
      output err_cnt
   );

endinterface

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for an n-bit Fibonacci LFSR stream.
// Seeds a local register from the incoming bits, confirms the sequence over
// LOCK_CNT matching bits, then free-runs and counts every deviating bit.
module lfsr_prbs_checker #(
   parameter int unsigned   n        = 8,
   parameter logic [n-1:0]  TAPS     = n'(8'hB8),
   parameter int unsigned   LOCK_CNT = 16,
   parameter int unsigned   LOST_CNT = 4,
   parameter int unsigned   CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   lfsr_prbs_checker_if.slave  bus
);

   localparam int unsigned FW = $clog2(n + 1);
   localparam int unsigned RW = $clog2(LOCK_CNT + 1);
   localparam int unsigned MW = $clog2(LOST_CNT + 1);

   typedef enum logic [1:0] {StSeed, StCheck, StLocked} state_e;

   state_e           state_q;
   logic [n-1:0]     s_q;
   logic [FW-1:0]    fill_q;
   logic [RW-1:0]    run_q;
   logic [MW-1:0]    miss_q;
   logic             locked_q;
   logic             err_pulse_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic             pred;
   logic             mismatch;
   logic             hit;
   logic [CNT_W-1:0] cnt_d;

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_cnt   = err_cnt_q;

   // Prediction, error qualification and saturating counter next-state.
   always_comb begin
      pred     = ^(s_q & TAPS);
      mismatch = (bus.in_bit != pred);
      hit      = bus.in_valid && (state_q == StLocked) && mismatch;
      cnt_d    = err_cnt_q;
      if (bus.clr_cnt) begin
         // A clear coinciding with an error keeps that error.
         cnt_d = hit ? CNT_W'(1) : '0;
      end else if (hit && (err_cnt_q != '1)) begin
         cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Synchronisation FSM with registered status and error outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StSeed;
         s_q         <= '0;
         fill_q      <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         err_pulse_q <= hit;
         err_cnt_q   <= cnt_d;
         if (bus.in_valid) begin
            unique case (state_q)
               StSeed: begin
                  s_q <= {s_q[n-2:0], bus.in_bit};
                  if (fill_q == FW'(n - 1)) begin
                     state_q <= StCheck;
                     fill_q  <= '0;
                     run_q   <= '0;
                  end else begin
                     fill_q <= fill_q + FW'(1);
                  end
               end
               StCheck: begin
                  // Keep re-seeding from the stream until the prediction holds.
                  s_q <= {s_q[n-2:0], bus.in_bit};
                  if (s_q == '0) begin
                     // All-zero register is an LFSR lock-up state: start over.
                     state_q <= StSeed;
                     fill_q  <= '0;
                     run_q   <= '0;
                  end else if (!mismatch) begin
                     if (run_q == RW'(LOCK_CNT - 1)) begin
                        state_q  <= StLocked;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                        run_q    <= '0;
                     end else begin
                        run_q <= run_q + RW'(1);
                     end
                  end else begin
                     run_q <= '0;
                  end
               end
               StLocked: begin
                  // Free-run on the prediction so a bad bit cannot corrupt s.
                  s_q <= {s_q[n-2:0], pred};
                  if (mismatch) begin
                     if (miss_q == MW'(LOST_CNT - 1)) begin
                        state_q  <= StSeed;
                        locked_q <= 1'b0;
                        fill_q   <= '0;
                        miss_q   <= '0;
                     end else begin
                        miss_q <= miss_q + MW'(1);
                     end
                  end else begin
                     miss_q <= '0;
                  end
               end
               default: begin
                  state_q <= StSeed;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Randomised scoreboard bench for lfsr_prbs_checker: two instances (16-bit and
// 4-bit error counters) share one stream; a history-based reference model
// queues expected outputs and a negedge monitor compares them.
module tb_lfsr_prbs_checker;

   localparam int unsigned N    = 8;
   localparam logic [7:0]  TAPS = 8'hB8;
   localparam int          LOCK = 16;
   localparam int          LOST = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lfsr_prbs_checker_if #(.CNT_W(16)) if16 ();
   lfsr_prbs_checker_if #(.CNT_W(4))  if4  ();

   lfsr_prbs_checker #(.n(N), .TAPS(TAPS), .LOCK_CNT(LOCK), .LOST_CNT(LOST), .CNT_W(16)) u16 (
      .clk (clk),
      .rst (rst),
      .bus (if16.slave)
   );

   lfsr_prbs_checker #(.n(N), .TAPS(TAPS), .LOCK_CNT(LOCK), .LOST_CNT(LOST), .CNT_W(4)) u4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   typedef struct {
      int locked;
      int pulse;
      int cnt16;
      int cnt4;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   passed = 0;
   int   total  = 0;

   // Reference model state: bit history (index 0 = newest) plus progress counters.
   bit   hist[$];
   int   seeded, good_run, bad_run;
   bit   checking, m_locked;
   int   m_cnt16, m_cnt4;

   // Stimulus source: stream obeying the tap recurrence.
   logic [7:0] g = 8'h01;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_pred();
      bit p = 1'b0;
      for (int i = 0; i < int'(N); i++) if (TAPS[i]) p ^= hist[i];
      return p;
   endfunction

   function automatic bit hist_zero();
      for (int i = 0; i < int'(N); i++) if (hist[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void hist_push(input bit b);
      hist.push_front(b);
      void'(hist.pop_back());
   endfunction

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < int'(N); i++) hist.push_back(1'b0);
      seeded = 0; good_run = 0; bad_run = 0;
      checking = 1'b0; m_locked = 1'b0;
      m_cnt16 = 0; m_cnt4 = 0;
   endfunction

   function automatic void model_step(input bit v, input bit b, input bit clr);
      bit hit = 1'b0;
      bit p;
      if (v) begin
         p = m_pred();
         if (m_locked) begin
            hist_push(p);
            if (b != p) begin
               hit = 1'b1;
               bad_run++;
               if (bad_run == LOST) begin
                  m_locked = 1'b0;
                  seeded = 0;
               end
            end else bad_run = 0;
         end else if (checking) begin
            if (hist_zero()) begin
               hist_push(b);
               checking = 1'b0;
               seeded = 0;
            end else begin
               hist_push(b);
               if (b == p) begin
                  good_run++;
                  if (good_run == LOCK) begin
                     checking = 1'b0;
                     m_locked = 1'b1;
                     bad_run = 0;
                  end
               end else good_run = 0;
            end
         end else begin
            hist_push(b);
            seeded++;
            if (seeded == int'(N)) begin
               checking = 1'b1;
               good_run = 0;
            end
         end
      end
      if (clr) begin
         m_cnt16 = hit ? 1 : 0;
         m_cnt4  = hit ? 1 : 0;
      end else if (hit) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt4 < 15) m_cnt4++;
      end
      expq.push_back('{locked: int'(m_locked), pulse: int'(hit), cnt16: m_cnt16, cnt4: m_cnt4});
   endfunction

   task automatic gen_bit(output bit b);
      b = ^(g & TAPS);
      g = {g[6:0], b};
   endtask

   task automatic drive(input bit v, input bit b, input bit clr);
      #1;
      if16.in_valid = v; if16.in_bit = b; if16.clr_cnt = clr;
      if4.in_valid  = v; if4.in_bit  = b; if4.clr_cnt  = clr;
      @(posedge clk);
      model_step(v, b, clr);
   endtask

   task automatic clean(input int cnt, input bit clr = 1'b0);
      bit b;
      for (int i = 0; i < cnt; i++) begin
         gen_bit(b);
         drive(1'b1, b, clr);
      end
   endtask

   task automatic flipped(input bit clr = 1'b0);
      bit b;
      gen_bit(b);
      drive(1'b1, ~b, clr);
   endtask

   // Asynchronous reset asserted between clock edges, outputs checked at once.
   task automatic async_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_locked16", int'(if16.locked), 0);
      chk("rst_cnt16", int'(if16.err_cnt), 0);
      chk("rst_pulse16", int'(if16.err_pulse), 0);
      chk("rst_locked4", int'(if4.locked), 0);
      chk("rst_cnt4", int'(if4.err_cnt), 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Scoreboard monitor: one expected entry per clock, compared off the active edge.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         chk("locked16", int'(if16.locked), mon_e.locked);
         chk("locked4", int'(if4.locked), mon_e.locked);
         chk("pulse16", int'(if16.err_pulse), mon_e.pulse);
         chk("pulse4", int'(if4.err_pulse), mon_e.pulse);
         chk("cnt16", int'(if16.err_cnt), mon_e.cnt16);
         chk("cnt4", int'(if4.err_cnt), mon_e.cnt4);
      end
   end

   initial begin
      bit b;
      if16.in_valid = 1'b0; if16.in_bit = 1'b0; if16.clr_cnt = 1'b0;
      if4.in_valid  = 1'b0; if4.in_bit  = 1'b0; if4.clr_cnt  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk("init_locked", int'(if16.locked), 0);
      chk("init_pulse", int'(if16.err_pulse), 0);
      chk("init_cnt16", int'(if16.err_cnt), 0);
      chk("init_cnt4", int'(if4.err_cnt), 0);

      // Clean stream: lock exactly on the 24th bit, no errors over 1000 bits.
      clean(23);
      #2 chk("lock_bit23", int'(if16.locked), 0);
      clean(1);
      #2 chk("lock_bit24", int'(if16.locked), 1);
      clean(976);
      #2 chk("clean_cnt", int'(if16.err_cnt), 0);

      // Single flipped bit: one error, lock kept, no propagation.
      flipped();
      clean(20);
      #2 chk("single_cnt", int'(if16.err_cnt), 1);
      chk("single_locked", int'(if16.locked), 1);

      // Four consecutive flips: all counted, then unlock and relock after 24.
      for (int i = 0; i < 4; i++) flipped();
      #2 chk("lost_cnt", int'(if16.err_cnt), 5);
      chk("lost_locked", int'(if16.locked), 0);
      clean(23);
      #2 chk("relock_23", int'(if16.locked), 0);
      clean(1);
      #2 chk("relock_24", int'(if16.locked), 1);

      // Saturation and clear interactions.
      clean(1, 1'b1);
      #2 chk("clr_only_a", int'(if16.err_cnt), 0);
      for (int i = 0; i < 20; i++) begin
         flipped();
         clean(5);
      end
      #2 chk("sat_cnt4", int'(if4.err_cnt), 15);
      chk("sat_cnt16", int'(if16.err_cnt), 20);
      flipped(1'b1);
      #2 chk("clr_err_cnt4", int'(if4.err_cnt), 1);
      clean(1, 1'b1);
      #2 chk("clr_only_cnt4", int'(if4.err_cnt), 0);

      // Random errors and clears while mostly locked.
      for (int i = 0; i < 600; i++) begin
         gen_bit(b);
         drive(1'b1, b ^ ($urandom_range(0, 9) == 0), $urandom_range(0, 39) == 0);
      end

      // Random in_valid on a clean stream after reset.
      async_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b);
            drive(1'b1, b, 1'b0);
         end else begin
            drive(1'b0, $urandom_range(0, 1) == 1, 1'b0);
         end
      end
      clean(30);

      // Reset mid-lock, then an all-zero stream must never lock.
      #2 chk("prereset_locked", int'(if16.locked), 1);
      async_reset();
      for (int i = 0; i < 200; i++) drive(1'b1, 1'b0, 1'b0);
      #2 chk("zero_never_locks", int'(if16.locked), 0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
